// File: rtl/ts_tx_serializer.sv
// ts_tx_serializer: ordered-set FIFO feeding the lane encoder one symbol per cycle with K flags
module ts_tx_serializer #(
  parameter int DEPTH = 4,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ts_valid,
  input  logic [127:0]     ts,
  output logic             ts_tx_fifo_full,
  input  logic             flush,
  input  logic             tx_ready,
  output logic [7:0]       tx_sym,
  output logic             tx_k,
  output logic             tx_sym_valid,
  output logic             tx_os_start,
  output logic             overflow,
  output logic [CNT_W-1:0] os_sent_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);
  localparam logic [AW:0] THRESH  = (AW+1)'(DEPTH - SKID);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nx;
  logic [127:0] mem [DEPTH];
  logic [127:0] shreg;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count, count_nx;
  logic [3:0] idx;
  logic adv, last, pop, push;
  assign adv      = state == SEND && tx_ready;
  assign last     = adv && idx == 4'd15;
  // pop tests the pre-write count, so a same-cycle write never feeds the pop
  assign pop      = !flush && count != '0 && (state == IDLE || last);
  assign push     = ts_valid && !flush && (count != DEPTH_N || pop);
  assign count_nx = flush ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (pop ? SEND : IDLE) : (last && !pop ? IDLE : SEND);
  always_comb begin
    tx_sym_valid = state == SEND;
    tx_sym       = tx_sym_valid ? shreg[127:120] : 8'h00;
    tx_os_start  = tx_sym_valid && idx == 4'd0;
    tx_k         = tx_sym_valid && (idx == 4'd0 || ((idx == 4'd1 || idx == 4'd2) && tx_sym == 8'hF7));
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= ts;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      shreg           <= '0;
      idx             <= '0;
      ts_tx_fifo_full <= 1'b0;
      overflow        <= 1'b0;
      os_sent_cnt     <= '0;
    end else begin
      wr_ptr          <= wr_ptr + AW'(push);
      rd_ptr          <= flush ? wr_ptr : rd_ptr + AW'(pop);
      count           <= count_nx;
      ts_tx_fifo_full <= count_nx >= THRESH;
      overflow        <= overflow | (ts_valid & ~flush & ~push);
      if (last && os_sent_cnt != '1) os_sent_cnt <= os_sent_cnt + CNT_W'(1);
      shreg           <= pop ? mem[rd_ptr] : adv ? {shreg[119:0], 8'h00} : shreg;
      idx             <= pop ? 4'd0 : adv ? idx + 4'd1 : idx;
    end
endmodule

// File: tb/tb_ts_tx_serializer.sv
// tb_ts_tx_serializer: scoreboard bench for the ordered-set serializer
module tb_ts_tx_serializer;
  logic clk = 1'b0, rst_n = 1'b0, ts_valid = 1'b0, flush = 1'b0, tx_ready = 1'b1;
  logic [127:0] ts = '0;
  logic ts_tx_fifo_full, tx_k, tx_sym_valid, tx_os_start, overflow;
  logic [7:0] tx_sym;
  logic [15:0] os_sent_cnt;
  logic s_full, s_k, s_valid, s_start, s_ovf;
  logic [7:0] s_sym;
  logic [1:0] s_cnt;
  logic [9:0] q[$];
  logic [9:0] mexp;
  int n_cmp = 0, n_bad = 0;

  ts_tx_serializer dut (
    .clk(clk), .rst_n(rst_n), .ts_valid(ts_valid), .ts(ts), .ts_tx_fifo_full(ts_tx_fifo_full),
    .flush(flush), .tx_ready(tx_ready), .tx_sym(tx_sym), .tx_k(tx_k), .tx_sym_valid(tx_sym_valid),
    .tx_os_start(tx_os_start), .overflow(overflow), .os_sent_cnt(os_sent_cnt)
  );

  ts_tx_serializer #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .ts_valid(ts_valid), .ts(ts), .ts_tx_fifo_full(s_full),
    .flush(flush), .tx_ready(tx_ready), .tx_sym(s_sym), .tx_k(s_k), .tx_sym_valid(s_valid),
    .tx_os_start(s_start), .overflow(s_ovf), .os_sent_cnt(s_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk(input logic [7:0] n);
    return {8'hBC, n[0] ? 8'h01 : 8'hF7, 8'hF7, n[2] ? 8'hF7 : 8'hFF, 8'h06, 8'h00,
            {9{n[1] ? 8'h45 : 8'h4A}}, n};
  endfunction

  task automatic push_exp(input logic [127:0] v);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] s;
      s = 8'(v >> (120 - 8 * i));
      q.push_back({i == 0, i == 0 || ((i == 1 || i == 2) && s == 8'hF7), s});
    end
  endtask

  task automatic wr(input logic [127:0] v, input logic expect_ok);
    ts = v;
    ts_valid = 1'b1;
    if (expect_ok) push_exp(v);
    step();
    ts_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int c = 0;
    while ((q.size() != 0 || tx_sym_valid) && c < 3000) begin
      step();
      c++;
    end
    chk("drain_timeout", 32'(c < 3000), 1);
  endtask

  task automatic wait_start();
    int w = 0;
    while (!tx_os_start && w < 20) begin
      step();
      w++;
    end
    chk("start_timeout", 32'(w < 20), 1);
  endtask

  always @(negedge clk)
    if (rst_n && tx_sym_valid && tx_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_sym: got %h want none", {tx_os_start, tx_k, tx_sym});
      end else begin
        mexp = q.pop_front();
        chk("sym_k_start", {22'd0, tx_os_start, tx_k, tx_sym}, {22'd0, mexp});
      end
    end

  initial begin
    logic [127:0] a, ts1;
    int k, run, tog, frz_bad;
    logic last_full;
    #2;
    chk("rst_valid", tx_sym_valid, 0);
    chk("rst_full", ts_tx_fifo_full, 0);
    chk("rst_cnt", os_sent_cnt, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    chk("post_rst_valid", tx_sym_valid, 0);

    // single TS1: first symbol one edge after the pop
    ts1 = {48'hBCF7F7FF0600, {10{8'h4A}}};
    wr(ts1, 1'b1);
    chk("lat_idle", tx_sym_valid, 0);
    step();
    chk("lat_valid", tx_sym_valid, 1);
    chk("lat_start", tx_os_start, 1);
    chk("lat_sym0", tx_sym, 8'hBC);
    chk("lat_k0", tx_k, 1);
    wait_drain();
    chk("ts1_cnt", os_sent_cnt, 1);
    chk("ts1_idle", tx_sym_valid, 0);

    // streaming generator gated by registered full
    k = 0; run = 0; tog = 0; last_full = ts_tx_fifo_full;
    fork
      begin
        for (int c = 0; c < 80; c++) begin
          if (ts_tx_fifo_full != last_full) tog++;
          last_full = ts_tx_fifo_full;
          ts_valid = !ts_tx_fifo_full;
          if (ts_valid) begin
            ts = mk(8'(k + 16));
            push_exp(ts);
            k++;
          end
          step();
        end
        ts_valid = 1'b0;
      end
      begin
        wait_start();
        while (tx_sym_valid && run < 3000) begin
          run++;
          step();
        end
      end
    join
    chk("stream_no_gap", run, 16 * k);
    chk("stream_full_toggles", 32'(tog >= 2), 1);
    chk("stream_ovf", overflow, 0);
    wait_drain();
    chk("stream_cnt", os_sent_cnt, 1 + k);

    // hold tx_ready low on symbol 5 and overfill
    a = mk(8'h05);
    wr(a, 1'b1);
    wait_start();
    repeat (5) step();
    tx_ready = 1'b0;
    chk("hold_sym", tx_sym, a[87:80]);
    frz_bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 3) chk("full_at3", ts_tx_fifo_full, 1);
      if (c == 4) chk("ovf_before", overflow, 0);
      if (c < 5) begin
        ts = mk(8'(c + 8'h40));
        ts_valid = 1'b1;
        if (c < 4) push_exp(ts);
      end else ts_valid = 1'b0;
      step();
      if (tx_sym !== a[87:80] || tx_sym_valid !== 1'b1) frz_bad++;
    end
    chk("hold_frozen", frz_bad, 0);
    chk("ovf_set", overflow, 1);
    tx_ready = 1'b1;
    wait_drain();
    chk("ovf_sticky", overflow, 1);
    chk("hold_cnt", os_sent_cnt, 1 + k + 5);

    // asynchronous reset in the middle of a set
    wr(mk(8'h77), 1'b1);
    wait_start();
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", tx_sym_valid, 0);
    chk("arst_sym", tx_sym, 0);
    chk("arst_k", tx_k, 0);
    chk("arst_start", tx_os_start, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_cnt", os_sent_cnt, 0);
    q.delete();
    #3 rst_n = 1'b1;
    repeat (3) step();
    chk("arst_no_resume", tx_sym_valid, 0);

    // flush with three queued while a set is at idx 7
    a = mk(8'h81);
    wr(a, 1'b1);
    wr(mk(8'h82), 1'b0);
    wr(mk(8'h83), 1'b0);
    wr(mk(8'h84), 1'b0);
    repeat (5) step();
    chk("flush_idx7", tx_sym, a[71:64]);
    chk("flush_full_before", ts_tx_fifo_full, 1);
    flush = 1'b1;
    ts = mk(8'h85);
    ts_valid = 1'b1;
    step();
    flush = 1'b0;
    ts_valid = 1'b0;
    chk("flush_full_after", ts_tx_fifo_full, 0);
    chk("flush_inflight", tx_sym_valid, 1);
    wait_drain();
    repeat (3) step();
    chk("flush_idle", tx_sym_valid, 0);
    chk("flush_cnt", os_sent_cnt, 1);
    chk("flush_ovf", overflow, 0);

    // saturation on the narrow-counter instance
    chk("sat_cnt1", s_cnt, 1);
    wr(mk(8'h90), 1'b1);
    wr(mk(8'h93), 1'b1);
    wait_drain();
    chk("sat_at_max", s_cnt, 3);
    chk("main_cnt3", os_sent_cnt, 3);
    wr(mk(8'h94), 1'b1);
    wr(mk(8'h97), 1'b1);
    wait_drain();
    chk("sat_hold", s_cnt, 3);
    chk("main_cnt5", os_sent_cnt, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
